// File: rtl/mc_controller.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing for the CPU.
// Optional MC_MEM_TIMEOUT_EN adds a memory wait watchdog that traps into ERROR.
module mc_controller #(
  parameter int unsigned STATE_W = 4
`ifdef MC_MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               pc_sel,
  output logic               ir_load,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               rf_we,
  output logic               alu_src,
  output logic [1:0]         alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               halted,
  output logic               illegal,
`ifdef MC_MEM_TIMEOUT_EN
  output logic               timeout,
`endif
  output logic [STATE_W-1:0] state
);

  localparam logic [3:0] StFetch   = 4'd0;
  localparam logic [3:0] StDecode  = 4'd1;
  localparam logic [3:0] StExecR   = 4'd2;
  localparam logic [3:0] StExecI   = 4'd3;
  localparam logic [3:0] StMemAddr = 4'd4;
  localparam logic [3:0] StMemRd   = 4'd5;
  localparam logic [3:0] StMemWr   = 4'd6;
  localparam logic [3:0] StWbAlu   = 4'd7;
  localparam logic [3:0] StWbMem   = 4'd8;
  localparam logic [3:0] StBranch  = 4'd9;
  localparam logic [3:0] StIllegal = 4'd10;
  localparam logic [3:0] StHalt    = 4'd11;
  localparam logic [3:0] StError   = 4'd12;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpHalt  = 6'b111111;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       wait_expired;
  logic       in_wait;

  assign in_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

`ifdef MC_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wait_cnt_q;
  logic [CntW-1:0] wait_cnt_d;

  // Counts consecutive stalled cycles within one visit to a wait state.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_wait && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_expired = in_wait && !mem_ready && (wait_cnt_q == CntW'(TIMEOUT - 1));
  assign timeout      = !reset && (state_q == StError);
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StError;
        end
      end
      StDecode: begin
        case (opcode)
          OpRtype:    state_d = StExecR;
          OpAddi:     state_d = StExecI;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpHalt:     state_d = StHalt;
          default:    state_d = StIllegal;
        endcase
      end
      StExecR:   state_d = StWbAlu;
      StExecI:   state_d = StWbAlu;
      StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) begin
          state_d = StWbMem;
        end else if (wait_expired) begin
          state_d = StError;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
        end else if (wait_expired) begin
          state_d = StError;
        end
      end
      StWbAlu:   state_d = StFetch;
      StWbMem:   state_d = StFetch;
      StBranch:  state_d = StFetch;
      StIllegal: state_d = StFetch;
      StHalt:    state_d = StHalt;
      StError:   state_d = StError;
      // Unused encodings recover by refetching.
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  always_comb begin
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    ir_load    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    rf_we      = 1'b0;
    alu_src    = 1'b0;
    alu_op     = AluAdd;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_rd  = 1'b1;
          ir_load = mem_ready;
        end
        StExecR: begin
          alu_src = 1'b0;
          alu_op  = AluFunct;
        end
        StExecI: begin
          alu_src = 1'b1;
          alu_op  = AluAdd;
        end
        StMemAddr: begin
          alu_src = 1'b1;
          alu_op  = AluAdd;
        end
        StMemRd: begin
          mem_rd = 1'b1;
        end
        StMemWr: begin
          mem_wr = 1'b1;
          pc_en  = mem_ready;
        end
        StWbAlu: begin
          rf_we   = 1'b1;
          pc_en   = 1'b1;
          reg_dst = (opcode == OpRtype);
        end
        StWbMem: begin
          rf_we      = 1'b1;
          mem_to_reg = 1'b1;
          pc_en      = 1'b1;
        end
        StBranch: begin
          alu_src = 1'b0;
          alu_op  = AluSub;
          pc_en   = 1'b1;
          pc_sel  = zero;
        end
        StIllegal: begin
          illegal = 1'b1;
          pc_en   = 1'b1;
        end
        StHalt:  halted = 1'b1;
        StError: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = reset ? '0 : STATE_W'(state_q);

`ifndef SYNTHESIS
  a_no_wr_conflict: assert property (@(posedge clk) !(rf_we && mem_wr));
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its state sequence.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, pc_sel, ir_load, mem_rd, mem_wr, rf_we, alu_src;
  logic [1:0] alu_op;
  logic       reg_dst, mem_to_reg, halted, illegal;
  logic [3:0] state;
`ifdef MC_MEM_TIMEOUT_EN
  logic       timeout;
`endif

  int passed = 0;
  int total  = 0;

  // Control bit masks, bit order matches the ctl vector below.
  localparam logic [12:0] PC_EN   = 13'h1000;
  localparam logic [12:0] PC_SEL  = 13'h0800;
  localparam logic [12:0] IR_LOAD = 13'h0400;
  localparam logic [12:0] MEM_RD  = 13'h0200;
  localparam logic [12:0] MEM_WR  = 13'h0100;
  localparam logic [12:0] RF_WE   = 13'h0080;
  localparam logic [12:0] ALU_SRC = 13'h0040;
  localparam logic [12:0] OP_FN   = 13'h0020;
  localparam logic [12:0] OP_SUB  = 13'h0010;
  localparam logic [12:0] REG_DST = 13'h0008;
  localparam logic [12:0] M2R     = 13'h0004;
  localparam logic [12:0] HALTED  = 13'h0002;
  localparam logic [12:0] ILLEGAL = 13'h0001;
  localparam logic [12:0] NONE    = 13'h0000;

  logic [12:0] ctl;
  assign ctl = {pc_en, pc_sel, ir_load, mem_rd, mem_wr, rf_we, alu_src, alu_op,
                reg_dst, mem_to_reg, halted, illegal};

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .ir_load    (ir_load),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .rf_we      (rf_we),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .illegal    (illegal),
`ifdef MC_MEM_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_st, input logic [12:0] exp_ctl);
    #1;
    total++;
    assert (state === exp_st) passed++;
    else $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
    total++;
    assert (ctl === exp_ctl) passed++;
    else $error("FAIL %s ctl: got %013b expected %013b", tag, ctl, exp_ctl);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;

    // Reset and R-type
    tick(); chk("rst_c1", 4'd0, NONE);
    tick(); chk("rst_c2", 4'd0, NONE);
    reset = 1'b0;
    chk("r_fetch", 4'd0, MEM_RD | IR_LOAD);
    tick(); chk("r_decode", 4'd1, NONE);
    tick(); chk("r_exec", 4'd2, OP_FN);
    tick(); chk("r_wb", 4'd7, RF_WE | REG_DST | PC_EN);
    tick(); chk("r_back", 4'd0, MEM_RD | IR_LOAD);

    // lw with 3 stall cycles in MEM_RD
    opcode = 6'b100011;
    chk("lw_fetch", 4'd0, MEM_RD | IR_LOAD);
    tick(); chk("lw_decode", 4'd1, NONE);
    tick(); chk("lw_addr", 4'd4, ALU_SRC);
    tick(); mem_ready = 1'b0; chk("lw_rd1", 4'd5, MEM_RD);
    tick(); chk("lw_rd2", 4'd5, MEM_RD);
    tick(); chk("lw_rd3", 4'd5, MEM_RD);
    tick(); mem_ready = 1'b1; chk("lw_rd4", 4'd5, MEM_RD);
    tick(); chk("lw_wb", 4'd8, RF_WE | M2R | PC_EN);
    tick(); chk("lw_back", 4'd0, MEM_RD | IR_LOAD);

    // beq taken then not taken
    opcode = 6'b000100; zero = 1'b1;
    tick(); chk("beq1_decode", 4'd1, NONE);
    tick(); chk("beq1_br", 4'd9, PC_EN | PC_SEL | OP_SUB);
    tick(); zero = 1'b0; chk("beq1_back", 4'd0, MEM_RD | IR_LOAD);
    tick(); chk("beq0_decode", 4'd1, NONE);
    tick(); chk("beq0_br", 4'd9, PC_EN | OP_SUB);
    tick(); chk("beq0_back", 4'd0, MEM_RD | IR_LOAD);

    // sw with one stall in MEM_WR
    opcode = 6'b101011;
    tick(); chk("sw_decode", 4'd1, NONE);
    tick(); chk("sw_addr", 4'd4, ALU_SRC);
    tick(); mem_ready = 1'b0; chk("sw_wr1", 4'd6, MEM_WR);
    tick(); mem_ready = 1'b1; chk("sw_wr2", 4'd6, MEM_WR | PC_EN);
    tick(); chk("sw_back", 4'd0, MEM_RD | IR_LOAD);

    // Fetch stall, then illegal opcode
    mem_ready = 1'b0; opcode = 6'b010101;
    chk("fetch_stall0", 4'd0, MEM_RD);
    tick(); chk("fetch_stall1", 4'd0, MEM_RD);
    mem_ready = 1'b1;
    tick(); chk("ill_decode", 4'd1, NONE);
    tick(); chk("ill_pulse", 4'd10, ILLEGAL | PC_EN);
    tick(); chk("ill_back", 4'd0, MEM_RD | IR_LOAD);

    // addi
    opcode = 6'b001000;
    tick(); chk("addi_decode", 4'd1, NONE);
    tick(); chk("addi_exec", 4'd3, ALU_SRC);
    tick(); chk("addi_wb", 4'd7, RF_WE | PC_EN);
    tick(); chk("addi_back", 4'd0, MEM_RD | IR_LOAD);

    // Reset mid-instruction abandons it
    opcode = 6'b000000;
    tick(); chk("abort_decode", 4'd1, NONE);
    tick(); chk("abort_exec", 4'd2, OP_FN);
    reset = 1'b1;
    chk("abort_rst", 4'd0, NONE);
    tick(); reset = 1'b0; chk("abort_fetch", 4'd0, MEM_RD | IR_LOAD);

    // HALT holds for 20 cycles, reset recovers
    opcode = 6'b111111;
    tick(); chk("halt_decode", 4'd1, NONE);
    for (int i = 0; i < 20; i++) begin
      tick(); chk($sformatf("halt_%0d", i), 4'd11, HALTED);
    end
    reset = 1'b1;
    chk("halt_rst", 4'd0, NONE);
    tick(); reset = 1'b0; opcode = 6'b000000;
    chk("halt_fetch", 4'd0, MEM_RD | IR_LOAD);

`ifdef MC_MEM_TIMEOUT_EN
    // Watchdog: 16 stalled fetch cycles trap into ERROR
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_wait_%0d", i), 4'd0, MEM_RD);
      tick();
    end
    chk("to_error", 4'd12, HALTED);
    total++;
    assert (timeout === 1'b1) passed++;
    else $error("FAIL to_flag: got %0b expected 1", timeout);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_ok_wait_%0d", i), 4'd0, MEM_RD);
      tick();
    end
    mem_ready = 1'b1;
    chk("to_ok_last", 4'd0, MEM_RD | IR_LOAD);
    tick(); chk("to_ok_decode", 4'd1, NONE);
    total++;
    assert (timeout === 1'b0) passed++;
    else $error("FAIL to_flag_clr: got %0b expected 0", timeout);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the word-addressed single-issue CPU.
- Sequences each instruction through fetch, decode, execute, memory and write-back steps.
- Drives the PC update enable and branch select, and handshakes with instruction/data memory via mem_ready.
- Sits between the instruction register (supplies opcode), ALU (supplies zero), PC logic, register file and memory.

Parameters:
- STATE_W, 4, width of state output.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- zero  input  1  ALU zero flag; sampled in BRANCH.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_en  output  1  PC update strobe (one cycle per retired instruction).
- pc_sel  output  1  branch taken (pc_en & BRANCH & zero).
- ir_load  output  1  load IR from memory read data.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request.
- rf_we  output  1  register file write enable.
- alu_src  output  1  0 = register B, 1 = sign-extended immediate.
- alu_op  output  2  00 add, 01 subtract, 10 funct-decoded, 11 unused.
- reg_dst  output  1  1 = rd, 0 = rt.
- mem_to_reg  output  1  1 = write-back data from memory.
- halted  output  1  HALT state reached.
- illegal  output  1  one-cycle pulse on unknown opcode.
- state  output  STATE_W  current state encoding, for debug.

Behaviour:
- Single state register; all outputs decoded combinationally from state, plus opcode/zero/mem_ready where noted. No registered outputs.
- Reset: while reset=1 all outputs are 0. The state register loads FETCH on the clock edge where reset=1. Reset mid-instruction abandons it with no further pc_en/rf_we/mem_wr.
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, ILLEGAL=10, HALT=11, ERROR=12.
- FETCH: mem_rd=1; ir_load=mem_ready. Stays in FETCH while mem_ready=0, moves to DECODE when it is 1.
- DECODE: all controls 0. Next state by opcode:
  - 000000 → EXEC_R
  - 001000 (addi) → EXEC_I
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 111111 → HALT
  - any other opcode → ILLEGAL
- EXEC_R: alu_src=0, alu_op=10. Next state WB_ALU.
- EXEC_I: alu_src=1, alu_op=00. Next state WB_ALU.
- WB_ALU: rf_we=1, pc_en=1, reg_dst=1 only for R-type (opcode 000000). Next state FETCH.
- MEM_ADDR: alu_src=1, alu_op=00. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_rd=1; waits on mem_ready, then WB_MEM.
- WB_MEM: rf_we=1, mem_to_reg=1, reg_dst=0, pc_en=1. Next state FETCH.
- MEM_WR: mem_wr=1; pc_en=mem_ready; waits on mem_ready, then FETCH.
- BRANCH: alu_src=0, alu_op=01, pc_en=1, pc_sel=zero. Next state FETCH.
- ILLEGAL: illegal=1, pc_en=1, pc_sel=0 (instruction skipped). Next state FETCH.
- HALT: halted=1, all other controls 0. Leaves only on reset.
- ERROR: only reachable with the optional feature. halted=1, all other controls 0. Leaves only on reset.
- Latency with mem_ready tied to 1:
  - beq: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Exactly one pc_en pulse per non-halt instruction. rf_we and mem_wr are never both 1 in the same cycle.

Optional Feature:
- Macro: MC_MEM_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT (default 16) and a wait counter that clears on every state change and on reset.
  - Counts consecutive mem_ready=0 cycles in FETCH, MEM_RD and MEM_WR.
  - When the count reaches TIMEOUT with mem_ready still 0, the next state is ERROR.
  - Adds output timeout (1 bit), which is 1 while in ERROR.
- Undefined: no counter, no ERROR entry, no timeout port; FSM waits indefinitely on mem_ready.

Test Plan:
- Reset held 2 cycles, mem_ready=1, opcode=000000 → all outputs 0 during reset; after release state FETCH→DECODE→EXEC_R→WB_ALU; in WB_ALU rf_we=1, reg_dst=1, pc_en=1; back to FETCH at cycle 4.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles with mem_rd=1; WB_MEM has rf_we=1, mem_to_reg=1, pc_en=1; total 8 cycles.
- beq (000100) with zero=1 → BRANCH has pc_en=1, pc_sel=1, alu_op=01. Repeat with zero=0 → pc_sel=0.
- sw (101011) with mem_ready=0 then 1 → mem_wr=1 for 2 cycles; pc_en only in the ready cycle; rf_we never 1.
- opcode 010101 → ILLEGAL pulse, pc_en=1, no rf_we/mem_wr. Then opcode 111111 → halted=1 held for 20 cycles with no pc_en; reset returns to FETCH.
- MC_MEM_TIMEOUT_EN, TIMEOUT=16, mem_ready=0 in FETCH → ERROR after 16 wait cycles, timeout=1, halted=1. With mem_ready asserted on wait cycle 15 → normal DECODE.
